// File: rtl/bnn_fcc_pkg.sv
// bnn_fcc_pkg: shared message types, header field offsets and loader FSM states.
package bnn_fcc_pkg;
  typedef enum logic [7:0] {CFG_WEIGHTS = 8'd0, CFG_THRESH = 8'd1} cfg_msg_type_e;
  localparam int HDR_TYPE_LSB = 0;
  localparam int HDR_TYPE_W = 8;
  localparam int HDR_LAYER_LSB = 8;
  localparam int HDR_LAYER_W = 8;
  typedef enum logic [1:0] {HDR, LEN, PAYLOAD, DRAIN} cfg_state_e;
endpackage

// File: rtl/bnn_cfg_wr_reg.sv
// bnn_cfg_wr_reg: single-entry valid/ready register for the memory write port.
module bnn_cfg_wr_reg #(
  parameter int LAYER_W = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_W = 32,
  localparam int KW = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LAYER_W-1:0]    load_layer,
  input  logic                  load_thresh,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic [KW-1:0]         load_keep,
  input  logic                  load_fin,
  output logic                  valid,
  input  logic                  ready,
  output logic [LAYER_W-1:0]    layer,
  output logic                  thresh,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_W-1:0]     data,
  output logic [KW-1:0]         keep,
  output logic                  fin
);
  // load is only raised by the parent when the slot is free or draining this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      layer <= '0;
      thresh <= 1'b0;
      addr <= '0;
      data <= '0;
      keep <= '0;
      fin <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      layer <= load_layer;
      thresh <= load_thresh;
      addr <= load_addr;
      data <= load_data;
      keep <= load_keep;
      fin <= load_fin;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/bnn_config_loader.sv
// bnn_config_loader: parses framed config messages into a sequenced weight/threshold write port.
module bnn_config_loader
  import bnn_fcc_pkg::*;
#(
  parameter int CONFIG_BUS_WIDTH = 32,
  parameter int TOTAL_LAYERS = 4,
  parameter int ADDR_WIDTH = 16,
  localparam int NL = TOTAL_LAYERS - 1,
  localparam int LAYER_W = NL > 1 ? $clog2(NL) : 1,
  localparam int KW = CONFIG_BUS_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        config_valid,
  output logic                        config_ready,
  input  logic [CONFIG_BUS_WIDTH-1:0] config_data,
  input  logic [KW-1:0]               config_keep,
  input  logic                        config_last,
  output logic                        cfg_wr_valid,
  input  logic                        cfg_wr_ready,
  output logic [LAYER_W-1:0]          cfg_wr_layer,
  output logic                        cfg_wr_thresh,
  output logic [ADDR_WIDTH-1:0]       cfg_wr_addr,
  output logic [CONFIG_BUS_WIDTH-1:0] cfg_wr_data,
  output logic [KW-1:0]               cfg_wr_keep,
  output logic [NL-1:0]               weights_loaded,
  output logic [NL-1:0]               thresh_loaded,
  output logic                        config_done,
  output logic                        config_err,
  output logic                        config_err_sticky
);
  localparam logic [CONFIG_BUS_WIDTH-1:0] LEN_MAX = CONFIG_BUS_WIDTH'(1) << ADDR_WIDTH;
  cfg_state_e state_q, state_d;
  logic typ_q;
  logic [LAYER_W-1:0] layer_q;
  logic [ADDR_WIDTH:0] len_q, cnt_q;
  logic hs, hdr_bad, hdr_ok, len_bad, last_word, load, err_d, wr_fin, wr_fire;
  logic [LAYER_W-1:0] hdr_layer;
  assign config_ready = state_q != PAYLOAD || !cfg_wr_valid || cfg_wr_ready;
  assign hs = config_valid && config_ready;
  assign hdr_layer = config_data[HDR_LAYER_LSB +: LAYER_W];
  assign hdr_bad = config_data[HDR_TYPE_LSB +: HDR_TYPE_W] > CFG_THRESH
                || 32'(config_data[HDR_LAYER_LSB +: HDR_LAYER_W]) >= NL;
  assign hdr_ok = hs && state_q == HDR && !hdr_bad && !config_last;
  assign len_bad = config_data == '0 || config_data > LEN_MAX;
  assign last_word = cnt_q == len_q - (ADDR_WIDTH+1)'(1);
  assign load = hs && state_q == PAYLOAD;
  assign wr_fire = cfg_wr_valid && cfg_wr_ready;
  assign config_done = &{weights_loaded, thresh_loaded};
  always_comb begin
    state_d = state_q;
    err_d = 1'b0;
    if (hs) begin
      case (state_q)
        HDR: begin
          err_d = hdr_bad || config_last;
          state_d = config_last ? HDR : (hdr_bad ? DRAIN : LEN);
        end
        LEN: begin
          err_d = len_bad || config_last;
          state_d = config_last ? HDR : (len_bad ? DRAIN : PAYLOAD);
        end
        PAYLOAD: begin
          err_d = config_last != last_word;
          state_d = config_last ? HDR : (last_word ? DRAIN : PAYLOAD);
        end
        default: state_d = config_last ? HDR : DRAIN;
      endcase
    end
  end
  // a header clear is ordered after a final-write set so the newer message wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR;
      typ_q <= 1'b0;
      layer_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      weights_loaded <= '0;
      thresh_loaded <= '0;
      config_err <= 1'b0;
      config_err_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      config_err <= err_d;
      if (err_d) config_err_sticky <= 1'b1;
      if (load) cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
      if (hs && state_q == LEN) begin
        len_q <= config_data[ADDR_WIDTH:0];
        cnt_q <= '0;
      end
      if (wr_fire && wr_fin) begin
        if (cfg_wr_thresh) thresh_loaded[cfg_wr_layer] <= 1'b1;
        else weights_loaded[cfg_wr_layer] <= 1'b1;
      end
      if (hdr_ok) begin
        typ_q <= config_data[HDR_TYPE_LSB];
        layer_q <= hdr_layer;
        if (config_data[HDR_TYPE_LSB]) thresh_loaded[hdr_layer] <= 1'b0;
        else weights_loaded[hdr_layer] <= 1'b0;
      end
    end
  end
  bnn_cfg_wr_reg #(.LAYER_W(LAYER_W), .ADDR_WIDTH(ADDR_WIDTH), .DATA_W(CONFIG_BUS_WIDTH)) u_wr (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_layer(layer_q),
    .load_thresh(typ_q),
    .load_addr(cnt_q[ADDR_WIDTH-1:0]),
    .load_data(config_data),
    .load_keep(config_keep),
    .load_fin(config_last && last_word),
    .valid(cfg_wr_valid),
    .ready(cfg_wr_ready),
    .layer(cfg_wr_layer),
    .thresh(cfg_wr_thresh),
    .addr(cfg_wr_addr),
    .data(cfg_wr_data),
    .keep(cfg_wr_keep),
    .fin(wr_fin)
  );
endmodule

// File: tb/tb_bnn_config_loader.sv
// tb_bnn_config_loader: randomized message stream checked against a message-level reference model.
module tb_bnn_config_loader;
  localparam int NL = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic config_valid = 1'b0, config_ready, config_last = 1'b0;
  logic [31:0] config_data = '0;
  logic [3:0] config_keep = '0;
  logic cfg_wr_valid, cfg_wr_ready = 1'b1, cfg_wr_thresh;
  logic [1:0] cfg_wr_layer;
  logic [15:0] cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic [3:0] cfg_wr_keep;
  logic [NL-1:0] weights_loaded, thresh_loaded;
  logic config_done, config_err, config_err_sticky;
  always #5 clk = ~clk;
  bnn_config_loader dut (
    .clk(clk), .rst(rst),
    .config_valid(config_valid), .config_ready(config_ready), .config_data(config_data),
    .config_keep(config_keep), .config_last(config_last),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_layer(cfg_wr_layer),
    .cfg_wr_thresh(cfg_wr_thresh), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_keep(cfg_wr_keep), .weights_loaded(weights_loaded), .thresh_loaded(thresh_loaded),
    .config_done(config_done), .config_err(config_err), .config_err_sticky(config_err_sticky)
  );
  typedef struct packed {
    logic [1:0] layer;
    logic th;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0] keep;
    logic fin;
  } wr_t;
  wr_t expq[$];
  int errors = 0, checks = 0;
  int err_seen = 0, exp_err = 0, wr_cnt = 0, gap_max = 0, wr_base = 0;
  logic [NL-1:0] wl_m = '0, tl_m = '0;
  logic beat_wr = 1'b0, stall = 1'b0, rnd_rdy = 1'b0, done_drop_chk = 1'b0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    cfg_wr_ready = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(3, 0) != 0) : 1'b1);
  end
  logic p_load = 1'b0, p_stall = 1'b0, pend_fin = 1'b0, fin_t = 1'b0;
  logic [1:0] fin_l = '0;
  logic [54:0] p_fields = '0, cur;
  wr_t e;
  // write-port monitor: latency, hold-while-stalled, write order and loaded-bit timing
  always @(negedge clk) begin
    cur = {cfg_wr_layer, cfg_wr_thresh, cfg_wr_addr, cfg_wr_data, cfg_wr_keep};
    if (rst) begin
      p_load = 1'b0;
      p_stall = 1'b0;
      pend_fin = 1'b0;
      err_seen = 0;
    end else begin
      if (p_load || p_stall) check("wr_valid", 64'(cfg_wr_valid), 64'd1);
      else check("wr_idle", 64'(cfg_wr_valid), 64'd0);
      if (p_stall) check("wr_hold", 64'(cur), 64'(p_fields));
      if (pend_fin) check("loaded_set", 64'(fin_t ? thresh_loaded[fin_l] : weights_loaded[fin_l]), 64'd1);
      if (config_err) err_seen++;
      pend_fin = 1'b0;
      if (cfg_wr_valid && cfg_wr_ready) begin
        wr_cnt++;
        if (expq.size() == 0) check("wr_extra", 64'd1, 64'd0);
        else begin
          e = expq.pop_front();
          check("wr", 64'(cur), 64'({e.layer, e.th, e.addr, e.data, e.keep}));
          pend_fin = e.fin;
          fin_l = e.layer;
          fin_t = e.th;
        end
      end
      if (cfg_wr_valid && !cfg_wr_ready && config_valid && beat_wr) check("ready_stall", 64'(config_ready), 64'd0);
      p_load = config_valid && config_ready && beat_wr;
      p_stall = cfg_wr_valid && !cfg_wr_ready;
      p_fields = cur;
    end
  end
  task automatic beat(input logic [31:0] d, input logic last, input logic wr, input logic [3:0] k);
    bit ok;
    ok = 1'b0;
    config_data = d;
    config_keep = k;
    config_last = last;
    beat_wr = wr;
    config_valid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = config_ready;
    end
    if (!ok) check("beat_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    config_valid = 1'b0;
    beat_wr = 1'b0;
    repeat ($urandom_range(gap_max, 0)) begin
      @(posedge clk);
      #1;
    end
  endtask
  // model: header validity, length, payload count and last position decide writes, errors and loaded bits
  task automatic msg(input int typ, input int lay, input int nh, input int np);
    logic [15:0] up;
    logic [31:0] d;
    logic [3:0] k;
    logic last, wr;
    up = 16'($urandom);
    if (typ > 1 || lay >= NL) begin
      exp_err++;
      beat({up, 8'(lay), 8'(typ)}, 1'b0, 1'b0, 4'hf);
      beat(32'(nh), 1'b0, 1'b0, 4'hf);
      for (int i = 0; i < np; i++) beat($urandom, i == np - 1, 1'b0, 4'(3'd7));
      return;
    end
    if (typ == 1) tl_m[lay] = 1'b0;
    else wl_m[lay] = 1'b0;
    beat({up, 8'(lay), 8'(typ)}, 1'b0, 1'b0, 4'hf);
    if (done_drop_chk) begin
      @(negedge clk);
      check("done_drop", 64'(config_done), 64'd0);
      @(posedge clk);
      #1;
    end
    beat(32'(nh), 1'b0, 1'b0, 4'hf);
    if (nh == 0) begin
      exp_err++;
      for (int i = 0; i < np; i++) beat($urandom, i == np - 1, 1'b0, 4'hf);
      return;
    end
    for (int i = 0; i < np; i++) begin
      d = $urandom;
      k = 4'($urandom);
      last = i == np - 1;
      wr = i < nh;
      if (wr) expq.push_back('{2'(lay), 1'(typ), 16'(i), d, k, last && np == nh});
      beat(d, last, wr, k);
    end
    if (np != nh) exp_err++;
    else if (typ == 1) tl_m[lay] = 1'b1;
    else wl_m[lay] = 1'b1;
  endtask
  task automatic settle();
    for (int i = 0; i < 300 && (expq.size() != 0 || cfg_wr_valid); i++) @(negedge clk);
    check("drain", 64'(expq.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("weights_loaded", 64'(weights_loaded), 64'(wl_m));
    check("thresh_loaded", 64'(thresh_loaded), 64'(tl_m));
    check("config_done", 64'(config_done), 64'(&{wl_m, tl_m}));
    check("err_count", 64'(err_seen), 64'(exp_err));
    check("err_sticky", 64'(config_err_sticky), 64'(exp_err != 0));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    config_valid = 1'b0;
    beat_wr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    wl_m = '0;
    tl_m = '0;
    exp_err = 0;
    @(negedge clk);
    check("rst_wr_valid", 64'(cfg_wr_valid), 64'd0);
    check("rst_wr_fields", 64'({cfg_wr_layer, cfg_wr_thresh, cfg_wr_addr, cfg_wr_data, cfg_wr_keep}), 64'd0);
    check("rst_flags", 64'({weights_loaded, thresh_loaded, config_done, config_err, config_err_sticky}), 64'd0);
    check("rst_ready", 64'(config_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    do_reset();
    msg(0, 0, 3, 3);
    settle();
    for (int l = 0; l < NL; l++)
      for (int t = 0; t < 2; t++) msg(t, l, 2, 2);
    settle();
    done_drop_chk = 1'b1;
    msg(0, 1, 2, 2);
    done_drop_chk = 1'b0;
    settle();
    fork
      msg(1, 1, 8, 8);
      begin
        wr_base = wr_cnt;
        for (int i = 0; i < 300 && wr_cnt < wr_base + 2; i++) @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    settle();
    msg(0, 3, 2, 2);
    settle();
    msg(1, 0, 2, 2);
    settle();
    msg(0, 2, 4, 2);
    settle();
    msg(1, 2, 3, 3);
    settle();
    stall = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    beat({16'h0, 8'd2, 8'd0}, 1'b0, 1'b0, 4'hf);
    beat(32'd4, 1'b0, 1'b0, 4'hf);
    beat(32'hdead_beef, 1'b0, 1'b1, 4'hf);
    stall = 1'b0;
    do_reset();
    msg(0, 0, 2, 2);
    settle();
    rnd_rdy = 1'b1;
    gap_max = 2;
    for (int m = 0; m < 40; m++) begin
      int kind, n;
      kind = $urandom_range(9, 0);
      n = $urandom_range(6, 1);
      case (kind)
        0: msg($urandom_range(3, 0), $urandom_range(5, 3), n, $urandom_range(3, 1));
        1: msg($urandom_range(3, 2), $urandom_range(2, 0), n, n);
        2: msg($urandom_range(1, 0), $urandom_range(2, 0), 0, $urandom_range(3, 1));
        3: msg($urandom_range(1, 0), $urandom_range(2, 0), n + 1, $urandom_range(n, 1));
        4: msg($urandom_range(1, 0), $urandom_range(2, 0), n, n + $urandom_range(2, 1));
        default: msg($urandom_range(1, 0), $urandom_range(2, 0), n, n);
      endcase
      settle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
